// File: rtl/ft_fifo_dev_emu.sv
// Emulates the device side of a parallel byte FIFO bridge: host bytes queue to an
// rd_n-strobed master, master wr_n writes queue back to the host; latency host->rxf_n 2 cycles.

module ft_fifo_dev_emu_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [7:0]            din,
    input  logic                  pop,
    output logic [7:0]            dout,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;

    // Callers only push when not full and only pop when non-empty.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= din;
    end

    assign dout  = mem_q[rptr_q];
    assign count = count_q;
endmodule

module ft_fifo_dev_emu #(
    parameter int DEPTH_LOG2 = 4,
    parameter int RXF_GAP    = 2,
    parameter int TXE_GAP    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] host_din,
    input  logic       host_din_valid,
    output logic       host_din_ready,
    output logic [7:0] host_dout,
    output logic       host_dout_valid,
    input  logic       host_dout_ready,
    output logic       rxf_n,
    output logic       txe_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       data_oe,
    output logic       rd_err,
    output logic       wr_err
);
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);

    typedef enum logic [1:0] {R_IDLE, R_ACTIVE, R_GAP} rd_state_t;
    typedef enum logic       {W_READY, W_GAP}          wr_state_t;

    rd_state_t rd_state_q, rd_state_d;
    wr_state_t wr_state_q, wr_state_d;
    logic [7:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic rd_n_prev_q, wr_n_prev_q;
    logic rxf_n_q, rxf_n_d, txe_n_q, txe_n_d;
    logic data_oe_q, data_oe_d;
    logic [7:0] data_o_q, data_o_d;
    logic rd_err_q, rd_err_d, wr_err_q, wr_err_d;

    logic rd_fall, rd_rise, wr_fall;
    logic rx_push, rx_pop, tx_push, tx_pop;
    logic [7:0] rx_head, tx_head;
    logic [DEPTH_LOG2:0] rx_count, tx_count;

    ft_fifo_dev_emu_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .din(host_din),
        .pop(rx_pop), .dout(rx_head), .count(rx_count)
    );

    ft_fifo_dev_emu_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .din(data_i),
        .pop(tx_pop), .dout(tx_head), .count(tx_count)
    );

    assign rd_fall = rd_n_prev_q & ~rd_n;
    assign rd_rise = ~rd_n_prev_q & rd_n;
    assign wr_fall = wr_n_prev_q & ~wr_n;

    assign host_din_ready  = (rx_count != FULL_CNT);
    assign host_dout_valid = (tx_count != '0);
    assign rx_push         = host_din_valid & host_din_ready;
    assign tx_pop          = host_dout_valid & host_dout_ready;
    assign host_dout       = tx_head;

    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        data_oe_d  = data_oe_q;
        data_o_d   = data_o_q;
        rd_err_d   = rd_err_q;
        rx_pop     = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (rd_fall) begin
                    if (!rxf_n_q) begin
                        rd_state_d = R_ACTIVE;
                        data_oe_d  = 1'b1;
                        data_o_d   = rx_head;
                    end else begin
                        rd_err_d = 1'b1;
                    end
                end
            end
            R_ACTIVE: begin
                if (rd_rise) begin
                    rx_pop     = 1'b1;
                    data_oe_d  = 1'b0;
                    rd_state_d = R_GAP;
                    rd_cnt_d   = 8'(RXF_GAP);
                end
            end
            R_GAP: begin
                if (rd_fall) rd_err_d = 1'b1;
                if (rd_cnt_q == 8'd0) rd_state_d = R_IDLE;
                else                  rd_cnt_d   = rd_cnt_q - 8'd1;
            end
            default: rd_state_d = R_IDLE;
        endcase
        // Uses the pre-update occupancy so a fresh host byte shows up two cycles later.
        rxf_n_d = !((rd_state_d == R_IDLE) && (rx_count != '0));
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        wr_err_d   = wr_err_q;
        tx_push    = 1'b0;
        case (wr_state_q)
            W_READY: begin
                if (wr_fall) begin
                    if (!txe_n_q) begin
                        tx_push    = 1'b1;
                        wr_state_d = W_GAP;
                        wr_cnt_d   = 8'(TXE_GAP);
                    end else begin
                        wr_err_d = 1'b1;
                    end
                end
            end
            W_GAP: begin
                if (wr_fall) wr_err_d = 1'b1;
                if (wr_cnt_q == 8'd0) wr_state_d = W_READY;
                else                  wr_cnt_d   = wr_cnt_q - 8'd1;
            end
            default: wr_state_d = W_READY;
        endcase
        txe_n_d = !((wr_state_d == W_READY) && (tx_count != FULL_CNT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q  <= R_IDLE;
            wr_state_q  <= W_READY;
            rd_cnt_q    <= 8'd0;
            wr_cnt_q    <= 8'd0;
            rd_n_prev_q <= 1'b1;
            wr_n_prev_q <= 1'b1;
            rxf_n_q     <= 1'b1;
            txe_n_q     <= 1'b1;
            data_oe_q   <= 1'b0;
            data_o_q    <= 8'h00;
            rd_err_q    <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            rd_state_q  <= rd_state_d;
            wr_state_q  <= wr_state_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_n_prev_q <= rd_n;
            wr_n_prev_q <= wr_n;
            rxf_n_q     <= rxf_n_d;
            txe_n_q     <= txe_n_d;
            data_oe_q   <= data_oe_d;
            data_o_q    <= data_o_d;
            rd_err_q    <= rd_err_d;
            wr_err_q    <= wr_err_d;
        end
    end

    assign rxf_n   = rxf_n_q;
    assign txe_n   = txe_n_q;
    assign data_oe = data_oe_q;
    assign data_o  = data_o_q;
    assign rd_err  = rd_err_q;
    assign wr_err  = wr_err_q;
endmodule

// File: tb/tb_ft_fifo_dev_emu.sv
// Directed bench for ft_fifo_dev_emu with default parameters (16-deep FIFOs, gaps of 2).
module tb_ft_fifo_dev_emu;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] host_din;
    logic       host_din_valid;
    logic       host_din_ready;
    logic [7:0] host_dout;
    logic       host_dout_valid;
    logic       host_dout_ready;
    logic       rxf_n, txe_n;
    logic       rd_n, wr_n;
    logic [7:0] data_i, data_o;
    logic       data_oe, rd_err, wr_err;

    int n_cmp = 0;
    int n_err = 0;

    ft_fifo_dev_emu dut (
        .clk(clk), .rst(rst),
        .host_din(host_din), .host_din_valid(host_din_valid), .host_din_ready(host_din_ready),
        .host_dout(host_dout), .host_dout_valid(host_dout_valid), .host_dout_ready(host_dout_ready),
        .rxf_n(rxf_n), .txe_n(txe_n), .rd_n(rd_n), .wr_n(wr_n),
        .data_i(data_i), .data_o(data_o), .data_oe(data_oe),
        .rd_err(rd_err), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_host(input logic [7:0] v);
        host_din = v; host_din_valid = 1'b1;
        tick();
        host_din_valid = 1'b0;
    endtask

    // Waits (bounded) for rxf_n, then performs one rd_n strobe; returns the bus value seen.
    task automatic read_byte(output logic [7:0] b, output logic oe, output bit ok);
        int k;
        k = 0;
        while (rxf_n !== 1'b0 && k < 20) begin tick(); k++; end
        ok = (rxf_n === 1'b0);
        rd_n = 1'b0; tick();
        b = data_o; oe = data_oe;
        rd_n = 1'b1; tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; host_din = 8'h00; host_din_valid = 1'b0; host_dout_ready = 1'b0;
        rd_n = 1'b1; wr_n = 1'b1; data_i = 8'h00;
        tick(); tick();
        n_cmp++; if (rxf_n !== 1'b1) begin n_err++; $display("FAIL reset_rxf_n: got %b want 1", rxf_n); end
        n_cmp++; if (txe_n !== 1'b1) begin n_err++; $display("FAIL reset_txe_n: got %b want 1", txe_n); end
        n_cmp++; if (data_oe !== 1'b0 || data_o !== 8'h00) begin n_err++; $display("FAIL reset_data: got oe=%b do=%h want 0/00", data_oe, data_o); end
        n_cmp++; if (host_din_ready !== 1'b1 || host_dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_host: got rdy=%b vld=%b want 1/0", host_din_ready, host_dout_valid); end
        n_cmp++; if (rd_err !== 1'b0 || wr_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b%b want 00", rd_err, wr_err); end
        rst = 1'b0;
        tick();
        n_cmp++; if (txe_n !== 1'b0) begin n_err++; $display("FAIL reset_txe_release: got %b want 0", txe_n); end
    endtask

    task automatic test_read();
        push_host(8'h5A);
        n_cmp++; if (rxf_n !== 1'b1) begin n_err++; $display("FAIL read_rxf_n1: got %b want 1", rxf_n); end
        tick();
        n_cmp++; if (rxf_n !== 1'b0) begin n_err++; $display("FAIL read_rxf_n2: got %b want 0", rxf_n); end
        rd_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (data_oe !== 1'b1 || data_o !== 8'h5A) begin n_err++; $display("FAIL read_strobe[%0d]: got oe=%b do=%h want 1/5a", i, data_oe, data_o); end
        end
        rd_n = 1'b1;
        tick();
        n_cmp++; if (data_oe !== 1'b0 || rxf_n !== 1'b1) begin n_err++; $display("FAIL read_rise: got oe=%b rxf_n=%b want 0/1", data_oe, rxf_n); end
        repeat (5) tick();
        n_cmp++; if (rxf_n !== 1'b1 || rd_err !== 1'b0) begin n_err++; $display("FAIL read_empty_after: got rxf_n=%b rd_err=%b want 1/0", rxf_n, rd_err); end
    endtask

    task automatic test_write_fill();
        int k;
        host_dout_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            k = 0;
            while (txe_n !== 1'b0 && k < 10) begin tick(); k++; end
            n_cmp++; if (txe_n !== 1'b0) begin n_err++; $display("FAIL wr_txe_wait[%0d]: got %b want 0", i, txe_n); end
            data_i = 8'(i); wr_n = 1'b0;
            tick();
            if (i == 0) begin
                // wr_n held low through the gap: must not push a second time
                k = 0;
                while (txe_n !== 1'b0 && k < 10) begin tick(); k++; end
                n_cmp++; if (k !== 3) begin n_err++; $display("FAIL wr_gap_len: got %0d want 3", k); end
            end
            wr_n = 1'b1;
            tick();
        end
        repeat (6) tick();
        n_cmp++; if (txe_n !== 1'b1) begin n_err++; $display("FAIL wr_full_txe: got %b want 1", txe_n); end
        n_cmp++; if (wr_err !== 1'b0) begin n_err++; $display("FAIL wr_err_pre: got %b want 0", wr_err); end
        data_i = 8'hEE; wr_n = 1'b0;
        tick();
        n_cmp++; if (wr_err !== 1'b1) begin n_err++; $display("FAIL wr_err_17th: got %b want 1", wr_err); end
        wr_n = 1'b1;
        tick();
        host_dout_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (host_dout_valid !== 1'b1 || host_dout !== 8'(i)) begin n_err++; $display("FAIL wr_drain[%0d]: got vld=%b d=%h want 1/%h", i, host_dout_valid, host_dout, 8'(i)); end
            tick();
        end
        host_dout_ready = 1'b0;
        n_cmp++; if (host_dout_valid !== 1'b0) begin n_err++; $display("FAIL wr_drain_empty: got %b want 0", host_dout_valid); end
    endtask

    task automatic test_rx_full();
        logic [7:0] b, exp;
        logic oe;
        bit ok;
        host_din_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            host_din = 8'h10 + 8'(i);
            tick();
        end
        host_din = 8'h20;
        n_cmp++; if (host_din_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", host_din_ready); end
        tick(); tick();
        n_cmp++; if (host_din_ready !== 1'b0) begin n_err++; $display("FAIL full_hold: got %b want 0", host_din_ready); end
        read_byte(b, oe, ok);
        n_cmp++; if (!ok || b !== 8'h10 || oe !== 1'b1) begin n_err++; $display("FAIL full_read0: got ok=%0d b=%h oe=%b want 1/10/1", ok, b, oe); end
        n_cmp++; if (host_din_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_after_pop: got %b want 1", host_din_ready); end
        tick();
        host_din_valid = 1'b0;
        n_cmp++; if (host_din_ready !== 1'b0) begin n_err++; $display("FAIL full_refill: got %b want 0", host_din_ready); end
        for (int i = 0; i < 16; i++) begin
            exp = (i < 15) ? (8'h11 + 8'(i)) : 8'h20;
            read_byte(b, oe, ok);
            n_cmp++; if (!ok || b !== exp) begin n_err++; $display("FAIL full_drain[%0d]: got ok=%0d b=%h want 1/%h", i, ok, b, exp); end
        end
    endtask

    task automatic test_read_empty();
        logic [7:0] b;
        logic oe;
        bit ok;
        repeat (5) tick();
        rd_n = 1'b0;
        tick();
        n_cmp++; if (rd_err !== 1'b1 || data_oe !== 1'b0 || rxf_n !== 1'b1) begin n_err++; $display("FAIL empty_read: got err=%b oe=%b rxf_n=%b want 1/0/1", rd_err, data_oe, rxf_n); end
        rd_n = 1'b1;
        tick();
        push_host(8'h77);
        read_byte(b, oe, ok);
        n_cmp++; if (!ok || b !== 8'h77 || oe !== 1'b1) begin n_err++; $display("FAIL empty_then_read: got ok=%0d b=%h oe=%b want 1/77/1", ok, b, oe); end
    endtask

    task automatic test_simul();
        logic [7:0] b;
        logic oe;
        bit ok;
        int k;
        repeat (5) tick();
        push_host(8'hA1);
        k = 0;
        while (rxf_n !== 1'b0 && k < 10) begin tick(); k++; end
        rd_n = 1'b0;
        tick();
        n_cmp++; if (data_o !== 8'hA1 || data_oe !== 1'b1) begin n_err++; $display("FAIL simul_first: got do=%h oe=%b want a1/1", data_o, data_oe); end
        rd_n = 1'b1; host_din = 8'hB2; host_din_valid = 1'b1;
        tick();
        host_din_valid = 1'b0;
        k = 0;
        while (rxf_n !== 1'b0 && k < 10) begin tick(); k++; end
        n_cmp++; if (k !== 3) begin n_err++; $display("FAIL simul_gap: got %0d want 3", k); end
        read_byte(b, oe, ok);
        n_cmp++; if (!ok || b !== 8'hB2) begin n_err++; $display("FAIL simul_second: got ok=%0d b=%h want 1/b2", ok, b); end
        repeat (6) tick();
        n_cmp++; if (rxf_n !== 1'b1) begin n_err++; $display("FAIL simul_empty: got %b want 1", rxf_n); end
    endtask

    task automatic test_rst_mid();
        logic [7:0] b;
        logic oe;
        bit ok;
        int k;
        data_i = 8'h99; wr_n = 1'b0;
        tick();
        wr_n = 1'b1;
        tick();
        n_cmp++; if (host_dout_valid !== 1'b1 || host_dout !== 8'h99) begin n_err++; $display("FAIL rst_tx_pre: got vld=%b d=%h want 1/99", host_dout_valid, host_dout); end
        push_host(8'hC3);
        k = 0;
        while (rxf_n !== 1'b0 && k < 10) begin tick(); k++; end
        rd_n = 1'b0;
        tick();
        n_cmp++; if (data_oe !== 1'b1) begin n_err++; $display("FAIL rst_pre_oe: got %b want 1", data_oe); end
        rst = 1'b1;
        tick();
        n_cmp++; if (data_oe !== 1'b0 || rxf_n !== 1'b1 || txe_n !== 1'b1) begin n_err++; $display("FAIL rst_mid_ctl: got oe=%b rxf_n=%b txe_n=%b want 0/1/1", data_oe, rxf_n, txe_n); end
        n_cmp++; if (host_din_ready !== 1'b1 || host_dout_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_fifo: got rdy=%b vld=%b want 1/0", host_din_ready, host_dout_valid); end
        n_cmp++; if (rd_err !== 1'b0 || wr_err !== 1'b0 || data_o !== 8'h00) begin n_err++; $display("FAIL rst_mid_err: got %b%b do=%h want 00/00", rd_err, wr_err, data_o); end
        rd_n = 1'b1; rst = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if (rxf_n !== 1'b1 || rd_err !== 1'b0 || host_dout_valid !== 1'b0) begin n_err++; $display("FAIL rst_release: got rxf_n=%b err=%b vld=%b want 1/0/0", rxf_n, rd_err, host_dout_valid); end
        push_host(8'hD4);
        read_byte(b, oe, ok);
        n_cmp++; if (!ok || b !== 8'hD4) begin n_err++; $display("FAIL rst_after_read: got ok=%0d b=%h want 1/d4", ok, b); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_fill();
        test_rx_full();
        test_read_empty();
        test_simul();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
